// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between the requester and the nibble-serial adder.
// Latency: n/a (wiring only).
// Backpressure: none; START is sampled only while the adder is IDLE/DONE, BUSY tells the requester to wait.
interface nibble_serial_adder_if #(
    parameter int W = 16
) ();

    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_IN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] S;
    logic         CO;
    logic         OVF;

    // Requester side drives operands, observes status and result
    modport master (
        output START, A, B, C_IN,
        input  BUSY, DONE, S, CO, OVF
    );

    // Adder side
    modport slave (
        input  START, A, B, C_IN,
        output BUSY, DONE, S, CO, OVF
    );

endinterface

// File: rtl/nibble_serial_adder_x74283.sv
// x74283 model: 4-bit binary full adder with fast carry.
// Latency: purely combinational.
// Backpressure: none.
module x74283 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_co
);

    logic [4:0] w_sum5;

    // Five-bit sum so the carry out of bit 3 is kept
    always_comb begin
        w_sum5 = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_c};
    end

    assign o_s  = w_sum5[3:0];
    assign o_co = w_sum5[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one x74283, fed one nibble per clock LSB first, carry held in a flop.
// Latency: START at edge k -> DONE high in the cycle after edge k+NIBBLES; one add per NIBBLES+1 clocks.
// Backpressure: BUSY high during RUN; START is ignored while BUSY, in-flight add is unaffected.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic CP,
    input  logic MR_n,
    nibble_serial_adder_if.slave bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_a_sh;
    logic [W-1:0]       r_b_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_acc;
    logic               r_a_msb;
    logic               r_b_msb;
    logic [W-1:0]       r_s;
    logic               r_co;
    logic               r_ovf;

    logic [NIBBLE_W-1:0] w_nib_s;
    logic                w_nib_co;
    logic                w_last;
    logic                w_busy;
    logic                w_done;
    logic [W+NIBBLE_W-1:0] w_acc_ext;
    logic [W-1:0]        w_acc_next;

    // The single adder slice: low nibbles of the shift registers plus the held carry
    x74283 u_add (
        .i_a  (r_a_sh[NIBBLE_W-1:0]),
        .i_b  (r_b_sh[NIBBLE_W-1:0]),
        .i_c  (r_carry),
        .o_s  (w_nib_s),
        .o_co (w_nib_co)
    );

    assign w_last = (r_cnt == CNT_W'(NIBBLES - 1));

    // New nibble enters at the top and the accumulator shifts right, so after NIBBLES
    // steps nibble i sits at acc[4i+3:4i]; the extension keeps this legal for NIBBLES=1
    always_comb begin
        w_acc_ext  = {w_nib_s, r_acc};
        w_acc_next = w_acc_ext[W+NIBBLE_W-1:NIBBLE_W];
    end

    // State register
    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.START) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = bus.START ? ST_RUN : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-nibble datapath and result registers
    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.START) begin
                        r_a_sh  <= bus.A;
                        r_b_sh  <= bus.B;
                        r_carry <= bus.C_IN;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        // Operand sign bits are shifted out during RUN, keep them for OVF
                        r_a_msb <= bus.A[W-1];
                        r_b_msb <= bus.B[W-1];
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_nib_co;
                    r_a_sh  <= r_a_sh >> NIBBLE_W;
                    r_b_sh  <= r_b_sh >> NIBBLE_W;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_s   <= w_acc_next;
                        r_co  <= w_nib_co;
                        r_ovf <= (r_a_msb == r_b_msb) && (w_acc_next[W-1] != r_a_msb);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY = w_busy;
    assign bus.DONE = w_done;
    assign bus.S    = r_s;
    assign bus.CO   = r_co;
    assign bus.OVF  = r_ovf;

endmodule
